// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
//   state_t  : scan FSM states
//   SEG_OFF  : all segments off (active-low)
//   HEX_SEG  : hex digit 0-F to {g,f,e,d,c,b,a}, active-low
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-7-segment decoder.
//   i_digit : WIDTH-bit digit value; only bits [3:0] are decoded
//   o_segs  : {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_digit,
  output logic [6:0]       o_segs
);

  always_comb begin
    o_segs = HEX_SEG[i_digit[3:0]];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment display controller.
//   clk, reset   : clock, synchronous active-high reset
//   enable       : 1 = scanning, 0 = display dark
//   load         : strobe capturing value into the pending register
//   value        : DIGITS*WIDTH digit values, digit 0 in the LSBs
//   lz_suppress  : 1 = blank leading zeros (digit 0 always shown)
//   segments     : {g,f,e,d,c,b,a}, active-low
//   digit_sel    : one-hot active-low digit enable
//   frame_done   : one-cycle pulse during the last cycle of a frame
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] value,
  input  logic                    lz_suppress,
  output logic [6:0]              segments,
  output logic [DIGITS-1:0]       digit_sel,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  state_t                  r_state, w_nxt_state;
  logic [CNT_W-1:0]        r_cnt, w_nxt_cnt;
  logic [IDX_W-1:0]        r_idx, w_nxt_idx;
  logic [DIGITS*WIDTH-1:0] r_pending, r_active, w_nxt_active, w_load_val;
  logic [WIDTH-1:0]        w_digit;
  logic                    w_supp;
  logic [DIGITS-1:0]       w_sel_n;
  logic [6:0]              w_dec_seg;

  // A load coincident with a frame start takes effect immediately.
  assign w_load_val = load ? value : r_pending;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_idx    = r_idx;
    w_nxt_active = r_active;
    if (!enable) begin
      w_nxt_state = IDLE;
      w_nxt_cnt   = '0;
      w_nxt_idx   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt_state  = BLANK;
          w_nxt_cnt    = '0;
          w_nxt_idx    = '0;
          w_nxt_active = w_load_val;
        end
        BLANK: begin
          w_nxt_cnt = r_cnt + 1'b1;
          if (r_cnt == BLANK_LAST) w_nxt_state = SHOW;
        end
        SHOW: begin
          if (r_cnt == CNT_LAST) begin
            w_nxt_cnt   = '0;
            w_nxt_state = BLANK;
            if (r_idx == IDX_LAST) begin
              w_nxt_idx    = '0;
              w_nxt_active = w_load_val;
            end else begin
              w_nxt_idx = r_idx + 1'b1;
            end
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = '0;
          w_nxt_idx   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state values, so the digit being
  // entered is selected here; zero_run walks from the top digit down.
  always_comb begin
    logic        zero_run;
    int unsigned k;
    logic [WIDTH-1:0] dig;
    zero_run = 1'b1;
    k        = 0;
    dig      = '0;
    w_digit  = '0;
    w_supp   = 1'b0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      k        = DIGITS - 1 - j;
      dig      = WIDTH'(w_nxt_active >> (k * WIDTH));
      zero_run = zero_run && (dig == '0);
      if (IDX_W'(k) == w_nxt_idx) begin
        w_digit = dig;
        w_supp  = lz_suppress && zero_run && (k != 0);
      end
    end
    w_sel_n = ~(DIGITS'(1) << w_nxt_idx);
  end

  seg7_decoder #(.WIDTH(WIDTH)) u_dec (
    .i_digit (w_digit),
    .o_segs  (w_dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_pending  <= '0;
      r_active   <= '0;
      segments   <= SEG_OFF;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_idx    <= w_nxt_idx;
      r_active <= w_nxt_active;
      if (load) r_pending <= value;
      if (w_nxt_state == SHOW && !w_supp) begin
        segments  <= w_dec_seg;
        digit_sel <= w_sel_n;
      end else begin
        segments  <= SEG_OFF;
        digit_sel <= '1;
      end
      frame_done <= (w_nxt_state == SHOW) && (w_nxt_cnt == CNT_LAST) &&
                    (w_nxt_idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4;
  localparam int unsigned R = 16;
  localparam int unsigned B = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           load;
  logic [D*W-1:0] value;
  logic           lz_suppress;
  logic [6:0]     segments;
  logic [D-1:0]   digit_sel;
  logic           frame_done;

  seg7_scan_ctrl #(
    .DIGITS       (D),
    .WIDTH        (W),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .value       (value),
    .lz_suppress (lz_suppress),
    .segments    (segments),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: running flag, position within the frame, value regs.
  bit             m_run;
  int unsigned    m_t;
  logic [D*W-1:0] m_pending;
  logic [D*W-1:0] m_active;
  logic           m_lz;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [D*W-1:0] nv;
    nv = load ? value : m_pending;
    if (reset) begin
      m_run = 1'b0; m_t = 0; m_pending = '0; m_active = '0;
    end else begin
      if (!enable) begin
        m_run = 1'b0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1'b1; m_t = 0; m_active = nv;
      end else if (m_t == D*R-1) begin
        m_t = 0; m_active = nv;
      end else begin
        m_t++;
      end
      if (load) m_pending = value;
    end
    m_lz = lz_suppress;
  endtask

  task automatic compare();
    logic [6:0]     e_seg;
    logic [D-1:0]   e_sel;
    logic           e_fd;
    int unsigned    slot, pos;
    logic [D*W-1:0] sh;
    e_seg = 7'h7F; e_sel = '1; e_fd = 1'b0;
    if (m_run) begin
      slot = m_t / R;
      pos  = m_t % R;
      e_fd = (m_t == D*R-1);
      sh   = m_active >> (slot * W);
      if (pos >= B && !(m_lz && slot != 0 && sh == '0)) begin
        e_sel = ~(D'(1) << slot);
        e_seg = hex_tab[sh[3:0]];
      end
    end
    check("segments",   32'(segments),   32'(e_seg));
    check("digit_sel",  32'(digit_sel),  32'(e_sel));
    check("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic run_until(input int unsigned t);
    int unsigned g = 0;
    while (!(m_run && m_t == t) && g < 500) begin
      tick();
      g++;
    end
    check("run_until_bound", 32'(g < 500), 32'd1);
  endtask

  task automatic do_load(input logic [D*W-1:0] v);
    value = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    m_run = 1'b0; m_t = 0; m_pending = '0; m_active = '0; m_lz = 1'b0;
    reset = 1'b1; enable = 1'b1; load = 1'b0; value = '0; lz_suppress = 1'b0;

    // Reset held with enable high
    repeat (3) tick();
    check("rst_seg", 32'(segments), 32'h7F);
    check("rst_sel", 32'(digit_sel), 32'hF);
    check("rst_fd",  32'(frame_done), 32'h0);

    // Load 1234 while idle, then scan
    reset = 1'b0; enable = 1'b0;
    do_load(16'h1234);
    enable = 1'b1;
    repeat (3) tick();
    check("first_show_seg", 32'(segments), 32'h19);
    check("first_show_sel", 32'(digit_sel), 32'hE);
    repeat (2 * D * R) tick();

    // Leading-zero suppression
    lz_suppress = 1'b1;
    do_load(16'h0070);
    repeat (2 * D * R) tick();
    do_load(16'h0000);
    repeat (2 * D * R) tick();

    // Load mid-frame, then exactly on the frame_done cycle
    lz_suppress = 1'b0;
    do_load(16'h1234);
    run_until(0);
    run_until(R + 4);
    do_load(16'hABCD);
    run_until(D*R - 1);
    check("fd_at_last", 32'(frame_done), 32'h1);
    run_until(D*R - 1);
    do_load(16'hFFFF);
    repeat (D * R) tick();

    // Enable dropped mid-SHOW of slot 2
    run_until(2*R + 5);
    enable = 1'b0;
    tick();
    check("drop_sel", 32'(digit_sel), 32'hF);
    check("drop_seg", 32'(segments), 32'h7F);
    repeat (4) tick();
    enable = 1'b1;
    repeat (D * R + 5) tick();

    // Reset mid-SHOW clears pending/active
    run_until(R + 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_seg", 32'(segments), 32'h40);
    repeat (D * R) tick();

    // Randomized traffic
    for (int unsigned c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) lz_suppress = ~lz_suppress;
      load = ($urandom_range(0, 19) == 0);
      if (load) begin
        case ($urandom_range(0, 3))
          0:       value = D*W'($urandom_range(0, 15));
          1:       value = D*W'($urandom_range(0, 255));
          default: value = D*W'($urandom);
        endcase
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexing controller that shares one 7-segment bus among DIGITS display digits. Each digit gets an equal time slot, with a blanking gap between slots to prevent ghosting. New counter values are loaded through a pending register and applied only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the lab counter/debounce logic and the board's segment and digit-select pins.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
WIDTH, 4, bits per digit value (hex nibble)
REFRESH_DIV, 1000, clock cycles per digit slot (must be > BLANK_CYCLES)
BLANK_CYCLES, 8, cycles at the start of each slot with all outputs off

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
enable  in  1  1 = scanning, 0 = display dark
load  in  1  single-cycle strobe; captures value
value  in  DIGITS*WIDTH  digit values, digit 0 = LSBs = rightmost
lz_suppress  in  1  1 = blank leading zeros
segments  out  7  {g,f,e,d,c,b,a}, active-low
digit_sel  out  DIGITS  one-hot active-low digit enable
frame_done  out  1  one-cycle pulse at end of last slot

Behaviour:
- Reset: segments=7'h7F, digit_sel all ones, frame_done=0, pending=0, active=0, idx=0, slot counter=0, state=IDLE. Reset has priority over every other input.
- States:
  - IDLE: outputs dark, idx=0, counter=0. If enable=1, go to BLANK next cycle.
  - BLANK: outputs dark. Counter runs 0..BLANK_CYCLES-1, then go to SHOW.
  - SHOW: drives digit idx. Counter runs BLANK_CYCLES..REFRESH_DIV-1.
  - At counter=REFRESH_DIV-1: counter←0, idx←idx+1, state←BLANK.
  - When idx=DIGITS-1: idx wraps to 0, frame_done=1 for that cycle, frame boundary occurs.
- Slot length is exactly REFRESH_DIV cycles; a frame is DIGITS*REFRESH_DIV cycles.
- Outputs are registered and change on the clock edge that enters the state.
- SHOW drive: digit_sel bit idx=0 and all other bits=1; segments=decode(active digit idx).
- Load:
  - load=1 gives pending←value.
  - At each frame boundary: active←(load ? value : pending). A load coincident with the boundary is therefore used in the next frame.
  - On entry from IDLE to BLANK: active←(load ? value : pending).
- Leading zeros (lz_suppress=1):
  - Digit k is suppressed if digits DIGITS-1..k of active are all zero and k≠0. Digit 0 is always shown.
  - A suppressed digit keeps digit_sel all ones and segments=7'h7F for its whole slot, but still consumes the slot time.
- Decode, active-low hex 0-F:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - For WIDTH>4, bits above [3:0] are ignored.
- enable falling: go to IDLE on the next edge regardless of position. Outputs are dark on that edge; idx and counter clear. An in-progress frame is abandoned and frame_done does not pulse.
- enable rising: restart at idx 0, BLANK.
- Overlap: at most one digit_sel bit is low at any time. Two consecutive digits are never driven without an intervening BLANK of exactly BLANK_CYCLES cycles.

Decomposition:
- Package seg7_pkg:
  - state typedef enum {IDLE, BLANK, SHOW}.
  - SEG_OFF=7'h7F.
  - 16-entry hex-to-segment constant array.
- Sub-module seg7_decoder: combinational, WIDTH-bit digit in, 7-bit active-low segments out. Uses the package array.
- Top holds the FSM, counters, pending/active registers and leading-zero logic.

Test Plan:
Bench parameters: DIGITS=4, REFRESH_DIV=16, BLANK_CYCLES=2.
1. Reset held 3 cycles with enable=1 -> segments=7F, digit_sel=F, frame_done=0. After reset release, first SHOW starts 3 edges later.
2. load value=16'h1234, then enable=1, lz_suppress=0 -> slot0 cycles 2-15: digit_sel=1110, seg=19. Slot1: 1101/30. Slot2: 1011/24. Slot3: 0111/79. digit_sel=F in cycles 0-1 of each slot. frame_done high on the cycle at frame-relative count 63.
3. value=16'h0070, lz_suppress=1 -> slots 3 and 2 dark (digit_sel=F, seg=7F). Slot1: 1101/78. Slot0: 1110/40. value=16'h0000 -> only slot0 lit, 40.
4. Frame showing 16'h1234; load 16'hABCD during slot 1 -> slots 1-3 of that frame still show 3,2,1. Next frame: D=21, C=46, b=03, A=08. load 16'hFFFF exactly on the frame_done cycle -> next frame shows 0E on all digits.
5. enable dropped mid-SHOW of slot 2 -> next edge digit_sel=F, seg=7F, no frame_done. Re-enable -> 2 dark cycles, then slot0 (digit 0).
6. reset asserted mid-SHOW -> dark next edge. pending/active clear, so after re-enable with lz_suppress=0 all digits show 40.
